// File: rtl/instr_encoder.sv
// instr_encoder: assembles one RV32I instruction word from separate fields and
// tags it with a sequential word address. The tagged stream is intended for
// writing a program image into instruction memory.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   restart       reloads the address counter to BASE_ADDR and clears err_cnt
//   in_*          field bundle with a valid/ready handshake
//   out_*         encoded word, its word address and error flag (valid/ready)
//   err_cnt       saturating count of illegal bundles
//
// An illegal bundle is replaced by the canonical NOP (addi x0,x0,0), flagged
// with out_err, and still consumes an address.
module instr_encoder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_f3,
  input  logic [6:0]        in_f7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_cnt
);

  localparam logic [ADDR_W-1:0] Base = ADDR_W'(BASE_ADDR);
  localparam logic [31:0]       Nop  = 32'h0000_0013;

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  logic [31:0] enc_word;
  logic        legal;
  logic        fits_s12, fits_s13, fits_s21;

  // A value fits in N signed bits when bits [31:N-1] are all equal.
  assign fits_s12 = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
  assign fits_s13 = (in_imm[31:12] == '0) || (in_imm[31:12] == '1);
  assign fits_s21 = (in_imm[31:20] == '0) || (in_imm[31:20] == '1);

  always_comb begin
    enc_word = Nop;
    legal    = 1'b0;
    case (in_opcode)
      OpReg: begin
        legal    = 1'b1;
        enc_word = {in_f7, in_rs2, in_rs1, in_f3, in_rd, in_opcode};
      end
      OpLoad, OpJalr: begin
        legal    = fits_s12;
        enc_word = {in_imm[11:0], in_rs1, in_f3, in_rd, in_opcode};
      end
      OpImm: begin
        if (in_f3 == 3'b001 || in_f3 == 3'b101) begin
          // srai is the only shift that may carry funct7 = 0100000
          legal    = (in_imm[31:5] == '0) &&
                     ((in_f7 == 7'b0000000) || (in_f7 == 7'b0100000 && in_f3 == 3'b101));
          enc_word = {in_f7, in_imm[4:0], in_rs1, in_f3, in_rd, in_opcode};
        end else begin
          legal    = fits_s12;
          enc_word = {in_imm[11:0], in_rs1, in_f3, in_rd, in_opcode};
        end
      end
      OpStore: begin
        legal    = fits_s12;
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_f3, in_imm[4:0], in_opcode};
      end
      OpBranch: begin
        legal    = fits_s13 && !in_imm[0];
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_f3, in_imm[4:1], in_imm[11],
                    in_opcode};
      end
      OpJal: begin
        legal    = fits_s21 && !in_imm[0];
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      end
      OpLui, OpAuipc: begin
        legal    = (in_imm[11:0] == '0);
        enc_word = {in_imm[31:12], in_rd, in_opcode};
      end
      default: begin
        legal    = 1'b0;
        enc_word = Nop;
      end
    endcase
    if (!legal) enc_word = Nop;
  end

  // Two-entry FIFO: the head entry drives the outputs directly, so they hold
  // while stalled.
  logic [1:0]        cnt_q;
  logic [31:0]       tail_instr_q;
  logic [ADDR_W-1:0] tail_addr_q;
  logic              tail_err_q;
  logic [ADDR_W-1:0] addr_q;
  logic              push, pop;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= 2'd0;
      out_instr    <= 32'h0;
      out_addr     <= Base;
      out_err      <= 1'b0;
      tail_instr_q <= 32'h0;
      tail_addr_q  <= Base;
      tail_err_q   <= 1'b0;
      addr_q       <= Base;
      err_cnt      <= 8'd0;
    end else begin
      // Full buffer refuses pushes, so the tail-to-head move never collides.
      if (pop && cnt_q == 2'd2) begin
        out_instr <= tail_instr_q;
        out_addr  <= tail_addr_q;
        out_err   <= tail_err_q;
      end
      if (push) begin
        if (cnt_q == 2'd0 || pop) begin
          out_instr <= enc_word;
          out_addr  <= addr_q;
          out_err   <= !legal;
        end else begin
          tail_instr_q <= enc_word;
          tail_addr_q  <= addr_q;
          tail_err_q   <= !legal;
        end
      end
      cnt_q <= cnt_q + 2'(push) - 2'(pop);

      // restart overrides both the increment and the error count
      if (restart) begin
        addr_q  <= Base;
        err_cnt <= 8'd0;
      end else if (push) begin
        addr_q <= addr_q + 1'b1;
        if (!legal && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a directed vector table, hand-written
// stall / wrap / restart / reset sequences, and randomized traffic checked
// every cycle against a queue-based reference model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst, restart, in_valid, out_ready;
  logic [6:0]  in_opcode, in_f7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_f3;
  logic [31:0] in_imm;
  logic        in_ready, out_valid, out_err;
  logic [31:0] out_instr;
  logic [9:0]  out_addr;
  logic [7:0]  err_cnt;
  // second instance with a 2-bit address counter, fed the same stream
  logic        in_ready2, out_valid2, out_err2;
  logic [31:0] out_instr2;
  logic [1:0]  out_addr2;
  logic [7:0]  err_cnt2;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_f3(in_f3),
    .in_f7(in_f7), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err), .err_cnt(err_cnt)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_w2 (
    .clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid), .in_ready(in_ready2),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_f3(in_f3),
    .in_f7(in_f7), .in_imm(in_imm), .out_valid(out_valid2), .out_ready(out_ready),
    .out_instr(out_instr2), .out_addr(out_addr2), .out_err(out_err2), .err_cnt(err_cnt2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference encoder: legality from integer ranges, fields from the ISA layout.
  function automatic void model_enc(input logic [6:0] op, input logic [4:0] rd,
                                    input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic [2:0] f3, input logic [6:0] f7,
                                    input logic [31:0] imm,
                                    output logic [31:0] w, output logic err);
    int  s;
    bit  ok;
    s  = $signed(imm);
    ok = 1'b0;
    w  = 32'h13;
    case (op)
      7'h33: begin ok = 1'b1; w = {f7, rs2, rs1, f3, rd, op}; end
      7'h03, 7'h67: begin
        ok = (s >= -2048 && s <= 2047); w = {imm[11:0], rs1, f3, rd, op};
      end
      7'h13: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          ok = (imm < 32) && (f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5));
          w  = {f7, imm[4:0], rs1, f3, rd, op};
        end else begin
          ok = (s >= -2048 && s <= 2047); w = {imm[11:0], rs1, f3, rd, op};
        end
      end
      7'h23: begin
        ok = (s >= -2048 && s <= 2047); w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      end
      7'h63: begin
        ok = (s >= -4096 && s <= 4095) && (imm % 2 == 0);
        w  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      end
      7'h6F: begin
        ok = (s >= -1048576 && s <= 1048575) && (imm % 2 == 0);
        w  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      end
      7'h37, 7'h17: begin ok = (imm % 4096 == 0); w = {imm[31:12], rd, op}; end
      default: ok = 1'b0;
    endcase
    err = !ok;
    if (!ok) w = 32'h13;
  endfunction

  typedef struct {
    logic [31:0] instr;
    int          addr;
    logic        err;
  } ent_t;

  ent_t q[$];
  int   m_addr = 0;
  int   m_err  = 0;

  // Cycle monitor: compares the DUT against the model, then advances the model
  // to what the coming rising edge should produce.
  always @(negedge clk) begin
    int          occ;
    logic [31:0] w;
    logic        e;
    bit          acc;
    if (rst) begin
      q.delete();
      m_addr = 0;
      m_err  = 0;
    end else begin
      occ = q.size();
      check("mon_out_valid", 32'(out_valid), 32'(occ != 0));
      check("mon_in_ready", 32'(in_ready), 32'(occ < 2));
      check("mon_err_cnt", 32'(err_cnt), 32'(m_err));
      if (occ != 0) begin
        check("mon_out_instr", out_instr, q[0].instr);
        check("mon_out_addr", 32'(out_addr), 32'(q[0].addr));
        check("mon_out_err", 32'(out_err), 32'(q[0].err));
        check("mon_addr_w2", 32'(out_addr2), 32'(q[0].addr % 4));
      end
      acc = in_valid && occ < 2;
      if (occ != 0 && out_ready) void'(q.pop_front());
      if (acc) begin
        model_enc(in_opcode, in_rd, in_rs1, in_rs2, in_f3, in_f7, in_imm, w, e);
        q.push_back('{instr: w, addr: m_addr, err: e});
        if (e && m_err < 255) m_err++;
        m_addr = (m_addr + 1) % 1024;
      end
      if (restart) begin
        m_addr = 0;
        m_err  = 0;
      end
    end
  end

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    in_opcode = v.op;  in_rd = v.rd;  in_rs1 = v.rs1;  in_rs2 = v.rs2;
    in_f3     = v.f3;  in_f7 = v.f7;  in_imm = v.imm;
  endtask

  task automatic do_reset();
    rst = 1'b1; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    int   n_bad;
    int   seen;
    logic [1:0] addr_seq[5];
    vec_t rv;

    //            op     rd rs1 rs2 f3 f7     imm            instr          err
    vecs[0]  = '{7'h33, 3, 1, 2, 0, 7'h00, 32'd0,        32'h002081B3, 1'b0}; // add
    vecs[1]  = '{7'h13, 1, 0, 0, 0, 7'h00, 32'hFFFFFFFF, 32'hFFF00093, 1'b0}; // addi -1
    vecs[2]  = '{7'h63, 0, 1, 2, 0, 7'h00, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0}; // beq -4
    vecs[3]  = '{7'h6F, 1, 0, 0, 0, 7'h00, 32'd2048,     32'h001000EF, 1'b0}; // jal 2048
    vecs[4]  = '{7'h13, 1, 1, 0, 1, 7'h00, 32'd32,       32'h00000013, 1'b1}; // slli 32
    vecs[5]  = '{7'h13, 1, 0, 0, 0, 7'h00, 32'd2048,     32'h00000013, 1'b1}; // addi 2048
    vecs[6]  = '{7'h37, 5, 0, 0, 0, 7'h00, 32'h12345000, 32'h123452B7, 1'b0}; // lui
    vecs[7]  = '{7'h23, 0, 1, 2, 2, 7'h00, 32'd8,        32'h0020A423, 1'b0}; // sw
    vecs[8]  = '{7'h13, 3, 4, 0, 5, 7'h20, 32'd5,        32'h40525193, 1'b0}; // srai 5
    vecs[9]  = '{7'h7F, 1, 1, 1, 0, 7'h00, 32'd0,        32'h00000013, 1'b1}; // bad opcode
    vecs[10] = '{7'h63, 0, 1, 2, 0, 7'h00, 32'd3,        32'h00000013, 1'b1}; // odd branch
    vecs[11] = '{7'h13, 1, 1, 0, 1, 7'h20, 32'd3,        32'h00000013, 1'b1}; // slli f7=0x20

    do_reset();
    drive(vecs[0]);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    tick();

    // Directed vector table, one word in flight at a time.
    n_bad = 0;
    foreach (vecs[i]) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_instr", i), out_instr, vecs[i].exp_instr);
      check($sformatf("vec%0d_err", i), 32'(out_err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_addr", i), 32'(out_addr), 32'(i));
      if (vecs[i].exp_err) n_bad++;
      tick();
    end
    check("table_err_cnt", 32'(err_cnt), 32'(n_bad));

    // Stall: three back-to-back bundles with the consumer blocked.
    do_reset();
    out_ready = 1'b0;
    drive(vecs[0]); in_valid = 1'b1; tick();
    drive(vecs[1]); tick();
    drive(vecs[6]);
    @(negedge clk);
    check("stall_in_ready_low", 32'(in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      check("stall_hold_instr", out_instr, 32'h002081B3);
      check("stall_hold_addr", 32'(out_addr), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    check("stall_pop1_instr", out_instr, 32'hFFF00093);
    check("stall_pop1_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("stall_third_instr", out_instr, 32'h123452B7);
    check("stall_third_addr", 32'(out_addr), 32'd2);
    tick(); tick();

    // Address wrap on the 2-bit instance.
    do_reset();
    seen = 0;
    drive(vecs[0]);
    for (int c = 0; c < 20 && seen < 5; c++) begin
      in_valid = (c < 5);
      tick();
      @(negedge clk);
      if (out_valid2) begin
        addr_seq[seen] = out_addr2;
        seen++;
      end
    end
    in_valid = 1'b0;
    check("wrap_words_seen", 32'(seen), 32'd5);
    for (int k = 0; k < 5; k++)
      if (k < seen) check($sformatf("wrap_addr%0d", k), 32'(addr_seq[k]), 32'(k % 4));
    tick();

    // Restart coinciding with an illegal accept at address 5.
    do_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(vecs[(k == 2) ? 9 : 0]);
      tick();
    end
    drive(vecs[5]);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    drive(vecs[6]);
    @(negedge clk);
    check("restart_addr5", 32'(out_addr), 32'd5);
    check("restart_err_flag", 32'(out_err), 32'd1);
    check("restart_err_cnt", 32'(err_cnt), 32'd0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("restart_next_addr", 32'(out_addr), 32'd0);
    check("restart_next_instr", out_instr, 32'h123452B7);
    tick();

    // Randomized traffic; the monitor does the checking.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      case ($urandom_range(0, 9))
        0: rv.op = 7'h33;  1: rv.op = 7'h03;  2: rv.op = 7'h67;  3: rv.op = 7'h13;
        4: rv.op = 7'h23;  5: rv.op = 7'h63;  6: rv.op = 7'h6F;  7: rv.op = 7'h37;
        8: rv.op = 7'h17;  default: rv.op = 7'($urandom);
      endcase
      rv.rd  = 5'($urandom);
      rv.rs1 = 5'($urandom);
      rv.rs2 = 5'($urandom);
      rv.f3  = 3'($urandom);
      case ($urandom_range(0, 2))
        0: rv.f7 = 7'h00;  1: rv.f7 = 7'h20;  default: rv.f7 = 7'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: rv.imm = 32'($signed($urandom_range(0, 80)) - 40);
        1: rv.imm = 32'($signed($urandom_range(0, 16384)) - 8192) & ~32'h1;
        2: rv.imm = $urandom & 32'hFFFFF000;
        default: rv.imm = $urandom;
      endcase
      drive(rv);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      restart   = ($urandom_range(0, 63) == 0);
      tick();
    end
    restart   = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(vecs[0]);
    tick(); tick(); tick();

    // Reset asserted with a full buffer.
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_instr", out_instr, 32'd0);
    check("midrst_out_addr", 32'(out_addr), 32'd0);
    check("midrst_err_cnt", 32'(err_cnt), 32'd0);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
